// File: rtl/egress_rr_arbiter.sv
// rtl/egress_rr_arbiter.sv - round-robin whole-packet scheduler for the shared egress packet path
module egress_rr_arbiter #(
    parameter int SRC_NUM = 4,
    parameter int DW      = 134
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SRC_NUM-1:0]     in_src_enable,
    input  logic [SRC_NUM*DW-1:0]  in_src_pkt_q,
    output logic [SRC_NUM-1:0]     out_src_pkt_rd,
    input  logic [SRC_NUM-1:0]     in_src_valid_empty,
    input  logic [SRC_NUM-1:0]     in_src_valid_q,
    output logic [SRC_NUM-1:0]     out_src_valid_rd,
    output logic                   out_egress_pkt_wr,
    output logic [DW-1:0]          out_egress_pkt,
    input  logic                   in_egress_pkt_almostfull,
    output logic                   out_egress_pkt_valid_wr,
    output logic                   out_egress_pkt_valid,
    output logic [SRC_NUM-1:0]     out_src_send_pkt_add,
    output logic [SRC_NUM-1:0]     out_src_discard_pkt_add
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SEND     = 2'd1;
    localparam logic [1:0] DISCARD  = 2'd2;

    // Word type field values in the top two bits of every packet word
    localparam logic [1:0] HDR_TAIL = 2'b10;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [1:0]         grant;
    logic [1:0]         rr_ptr;

    logic [SRC_NUM-1:0] req;
    logic [1:0]         cand;
    logic [1:0]         pick;
    logic               pick_found;
    logic               arb_fire;

    logic [DW-1:0]      src_word [SRC_NUM];
    logic [DW-1:0]      cur_word;
    logic               cur_tail;
    logic               in_packet;

    // A source competes only when enabled and its valid FIFO holds a complete packet
    assign req = in_src_enable & ~in_src_valid_empty;

    genvar gi;
    for (gi = 0; gi < SRC_NUM; gi++) begin : g_unpack
        assign src_word[gi] = in_src_pkt_q[gi*DW +: DW];
    end

    assign cur_word  = src_word[grant];
    assign cur_tail  = (cur_word[DW-1 -: 2] == HDR_TAIL);
    assign in_packet = reset && ((state == SEND) || (state == DISCARD));

    // Scan requesters from rr_ptr+1 upward; the descending loop lets the nearest one win,
    // and the 4th candidate wraps back to rr_ptr itself as lowest priority
    always_comb begin
        pick       = rr_ptr;
        pick_found = 1'b0;
        cand       = rr_ptr;
        for (int k = SRC_NUM; k >= 1; k--) begin
            cand = rr_ptr + 2'(k);
            if (req[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    // Arbitration happens only from IDLE, only with downstream headroom, never during reset
    assign arb_fire = reset && (state == IDLE) && !in_egress_pkt_almostfull && pick_found;

    // Read strobes: valid FIFO popped once at grant, pkt FIFO popped every cycle of the packet
    always_comb begin
        out_src_valid_rd = '0;
        out_src_pkt_rd   = '0;
        if (arb_fire) begin
            out_src_valid_rd[pick] = 1'b1;
        end
        if (in_packet) begin
            out_src_pkt_rd[grant] = 1'b1;
        end
    end

    // Next-state: good packets are forwarded, bad ones drained; both end on a tail word
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (arb_fire) begin
                    state_nxt = in_src_valid_q[pick] ? SEND : DISCARD;
                end
            end
            SEND, DISCARD: begin
                if (cur_tail) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, current grant and round-robin pointer; the pointer moves to the winner at every grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            grant  <= 2'd0;
            rr_ptr <= 2'd3;
        end else begin
            state <= state_nxt;
            if (arb_fire) begin
                grant  <= pick;
                rr_ptr <= pick;
            end
        end
    end

    // Registered egress outputs and per-source counters; everything defaults back to 0 each cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_egress_pkt_wr       <= 1'b0;
            out_egress_pkt          <= '0;
            out_egress_pkt_valid_wr <= 1'b0;
            out_egress_pkt_valid    <= 1'b0;
            out_src_send_pkt_add    <= '0;
            out_src_discard_pkt_add <= '0;
        end else begin
            out_egress_pkt_wr       <= 1'b0;
            out_egress_pkt          <= '0;
            out_egress_pkt_valid_wr <= 1'b0;
            out_egress_pkt_valid    <= 1'b0;
            out_src_send_pkt_add    <= '0;
            out_src_discard_pkt_add <= '0;
            if (state == SEND) begin
                out_egress_pkt_wr <= 1'b1;
                out_egress_pkt    <= cur_word;
                if (cur_tail) begin
                    out_egress_pkt_valid_wr     <= 1'b1;
                    out_egress_pkt_valid        <= 1'b1;
                    out_src_send_pkt_add[grant] <= 1'b1;
                end
            end else if ((state == DISCARD) && cur_tail) begin
                out_src_discard_pkt_add[grant] <= 1'b1;
            end
        end
    end

endmodule
